// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle main control FSM for the MIPS-subset CPU: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives datapath strobes, bounds memory waits and counts retired instructions.
module multi_cycle_ctrl #(
    parameter int OP_W        = 6,
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4,
    parameter int CNT_W       = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OP_W-1:0]    instr_op_i,
    input  logic               imem_ready_i,
    input  logic               dmem_ready_i,
    output logic               imem_req_o,
    output logic               dmem_read_o,
    output logic               dmem_write_o,
    output logic               ir_write_o,
    output logic               pc_write_o,
    output logic [1:0]         pc_src_o,
    output logic               branch_o,
    output logic               branch_ne_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               alu_src_o,
    output logic               reg_write_o,
    output logic [1:0]         reg_dst_o,
    output logic [1:0]         mem_to_reg_o,
    output logic               illegal_o,
    output logic               bus_err_o,
    output logic [2:0]         state_o,
    output logic [CNT_W-1:0]   retire_cnt_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'h02);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'h03);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'h05);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'h08);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'h0D);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(6'h0F);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);

    localparam logic [1:0] PC_SRC_SEQ = 2'b00;
    localparam logic [1:0] PC_SRC_BR  = 2'b01;
    localparam logic [1:0] PC_SRC_JMP = 2'b10;

    // Packs {alu_op, alu_src} for an opcode; unknown opcodes yield zero.
    function automatic logic [ALUOP_W:0] f_alu_ctrl(input logic [OP_W-1:0] op);
        logic [ALUOP_W:0] v;
        v = '0;
        case (op)
            OP_RTYPE: v = {ALUOP_W'(3'b010), 1'b0};
            OP_ADDI:  v = {ALUOP_W'(3'b000), 1'b1};
            OP_BEQ:   v = {ALUOP_W'(3'b001), 1'b0};
            OP_BNE:   v = {ALUOP_W'(3'b011), 1'b0};
            OP_ORI:   v = {ALUOP_W'(3'b100), 1'b1};
            OP_LUI:   v = {ALUOP_W'(3'b101), 1'b1};
            OP_LW:    v = {ALUOP_W'(3'b000), 1'b1};
            OP_SW:    v = {ALUOP_W'(3'b000), 1'b1};
            default:  v = '0;
        endcase
        return v;
    endfunction

    function automatic logic f_is_legal(input logic [OP_W-1:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
            OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t             r_state;
    logic [TO_W-1:0]    r_wait;
    logic [OP_W-1:0]    r_op;
    logic [CNT_W-1:0]   r_retire;

    state_t             w_next;
    logic               w_wait_inc;
    logic               w_retire;
    logic               w_timeout;
    logic [ALUOP_W:0]   w_alu_ctrl;

    logic               w_imem_req;
    logic               w_dmem_read;
    logic               w_dmem_write;
    logic               w_ir_write;
    logic               w_pc_write;
    logic [1:0]         w_pc_src;
    logic               w_branch;
    logic               w_branch_ne;
    logic [ALUOP_W-1:0] w_alu_op;
    logic               w_alu_src;
    logic               w_reg_write;
    logic [1:0]         w_reg_dst;
    logic [1:0]         w_mem_to_reg;
    logic               w_illegal;
    logic               w_bus_err;

    assign w_timeout  = (r_wait == TO_W'(MEM_TIMEOUT));
    assign w_alu_ctrl = f_alu_ctrl(r_op);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_FETCH;
            r_wait   <= '0;
            r_op     <= '0;
            r_retire <= '0;
        end else begin
            r_state <= w_next;
            // Any state change or timeout retry leaves w_wait_inc low, clearing the counter.
            r_wait  <= w_wait_inc ? r_wait + TO_W'(1) : '0;
            if (r_state == S_DECODE) begin
                r_op <= instr_op_i;
            end
            if (w_retire) begin
                r_retire <= r_retire + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_wait_inc   = 1'b0;
        w_retire     = 1'b0;
        w_imem_req   = 1'b0;
        w_dmem_read  = 1'b0;
        w_dmem_write = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_src     = PC_SRC_SEQ;
        w_branch     = 1'b0;
        w_branch_ne  = 1'b0;
        w_alu_op     = '0;
        w_alu_src    = 1'b0;
        w_reg_write  = 1'b0;
        w_reg_dst    = 2'b00;
        w_mem_to_reg = 2'b00;
        w_illegal    = 1'b0;
        w_bus_err    = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ready_i) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_timeout) begin
                    w_bus_err = 1'b1;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end

            // r_op is only captured at the end of DECODE, so jumps and illegal
            // detection here have to look at the IR opcode directly.
            S_DECODE: begin
                if (instr_op_i == OP_J || instr_op_i == OP_JAL) begin
                    w_pc_write = 1'b1;
                    w_pc_src   = PC_SRC_JMP;
                    w_retire   = 1'b1;
                    w_next     = S_FETCH;
                    if (instr_op_i == OP_JAL) begin
                        w_reg_write  = 1'b1;
                        w_reg_dst    = 2'b10;
                        w_mem_to_reg = 2'b10;
                    end
                end else if (!f_is_legal(instr_op_i)) begin
                    w_illegal = 1'b1;
                    w_next    = S_FETCH;
                end else begin
                    w_next = S_EXEC;
                end
            end

            S_EXEC: begin
                w_alu_op  = w_alu_ctrl[ALUOP_W:1];
                w_alu_src = w_alu_ctrl[0];
                if (r_op == OP_BEQ || r_op == OP_BNE) begin
                    w_branch    = 1'b1;
                    w_branch_ne = (r_op == OP_BNE);
                    w_pc_src    = PC_SRC_BR;
                    w_retire    = 1'b1;
                    w_next      = S_FETCH;
                end else if (r_op == OP_LW || r_op == OP_SW) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end

            S_MEM: begin
                if (r_op == OP_LW || r_op == OP_SW) begin
                    w_dmem_read  = (r_op == OP_LW);
                    w_dmem_write = (r_op == OP_SW);
                    if (dmem_ready_i) begin
                        if (r_op == OP_LW) begin
                            w_next = S_WB;
                        end else begin
                            w_retire = 1'b1;
                            w_next   = S_FETCH;
                        end
                    end else if (w_timeout) begin
                        w_bus_err = 1'b1;
                        w_next    = S_FETCH;
                    end else begin
                        w_wait_inc = 1'b1;
                    end
                end else begin
                    w_next = S_FETCH;
                end
            end

            S_WB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = (r_op == OP_RTYPE) ? 2'b01 : 2'b00;
                w_mem_to_reg = (r_op == OP_LW) ? 2'b01 : 2'b00;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end

            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Reset masks every strobe immediately, before the first reset edge lands.
    assign imem_req_o   = w_imem_req   & ~rst_i;
    assign dmem_read_o  = w_dmem_read  & ~rst_i;
    assign dmem_write_o = w_dmem_write & ~rst_i;
    assign ir_write_o   = w_ir_write   & ~rst_i;
    assign pc_write_o   = w_pc_write   & ~rst_i;
    assign pc_src_o     = rst_i ? 2'b00 : w_pc_src;
    assign branch_o     = w_branch     & ~rst_i;
    assign branch_ne_o  = w_branch_ne  & ~rst_i;
    assign alu_op_o     = rst_i ? '0 : w_alu_op;
    assign alu_src_o    = w_alu_src    & ~rst_i;
    assign reg_write_o  = w_reg_write  & ~rst_i;
    assign reg_dst_o    = rst_i ? 2'b00 : w_reg_dst;
    assign mem_to_reg_o = rst_i ? 2'b00 : w_mem_to_reg;
    assign illegal_o    = w_illegal    & ~rst_i;
    assign bus_err_o    = w_bus_err    & ~rst_i;
    assign state_o      = rst_i ? 3'd0 : r_state;
    assign retire_cnt_o = r_retire;

endmodule
